// File: rtl/xadac_issue_if.sv
// xadac accelerator channel types and the four-channel valid/ready interface.
// Vector registers are VLanes lanes of XLen bits each.
package xadac_pkg;
    localparam int XadacIdWidth = 4;
    localparam int XadacXLen    = 32;
    localparam int VLanes       = 4;
    localparam int VLen         = VLanes * XadacXLen;

    typedef logic [XadacIdWidth-1:0] id_t;
    typedef logic [XadacXLen-1:0]    xdata_t;
    typedef logic [VLen-1:0]         vdata_t;

    typedef struct packed {
        id_t         id;
        logic [31:0] instr;
    } dec_req_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] rs_read;
        logic [2:0] vs_read;
        logic       rd_clobber;
        logic       vd_clobber;
        logic       accept;
    } dec_rsp_t;

    typedef struct packed {
        id_t               id;
        logic [31:0]       instr;
        xdata_t [1:0]      rs_data;
        vdata_t [2:0]      vs_data;
    } exe_req_t;

    typedef struct packed {
        id_t    id;
        vdata_t vd;
        xdata_t rd;
    } exe_rsp_t;
endpackage

interface xadac_if;
    import xadac_pkg::*;

    logic     dec_req_valid;
    logic     dec_req_ready;
    dec_req_t dec_req;
    logic     dec_rsp_valid;
    logic     dec_rsp_ready;
    dec_rsp_t dec_rsp;
    logic     exe_req_valid;
    logic     exe_req_ready;
    exe_req_t exe_req;
    logic     exe_rsp_valid;
    logic     exe_rsp_ready;
    exe_rsp_t exe_rsp;

    modport mst (
        output dec_req_valid, dec_req, input dec_req_ready,
        input dec_rsp_valid, dec_rsp, output dec_rsp_ready,
        output exe_req_valid, exe_req, input exe_req_ready,
        input exe_rsp_valid, exe_rsp, output exe_rsp_ready
    );

    modport slv (
        input dec_req_valid, dec_req, output dec_req_ready,
        output dec_rsp_valid, dec_rsp, input dec_rsp_ready,
        input exe_req_valid, exe_req, output exe_req_ready,
        output exe_rsp_valid, exe_rsp, input exe_rsp_ready
    );
endinterface

// File: rtl/xadac_issue.sv
// Single-issue xadac initiator: decode, execute with local VRF operands,
// then commit vector result to the VRF and scalar result to writeback.
module xadac_issue
    import xadac_pkg::*;
#(
    parameter int NumVregs = 8,
    parameter int IdWidth  = XadacIdWidth,
    parameter int XLen     = XadacXLen
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLen-1:0] in_rs1,
    input  logic [XLen-1:0] in_rs2,
    output logic            rej_o,
    output logic            err_o,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLen-1:0] wb_data,
    xadac_if.mst            mst
);
    localparam int VIdx = (NumVregs > 1) ? $clog2(NumVregs) : 1;

    typedef enum logic [1:0] {IDLE, DEC, EXE, WB} state_e;

    state_e               state_q, state_d;
    logic [IdWidth-1:0]   id_cnt_q, id_cnt_d;
    logic [IdWidth-1:0]   cur_id_q, cur_id_d;
    logic [31:0]          instr_q, instr_d;
    logic [XLen-1:0]      rs1_q, rs1_d;
    logic [XLen-1:0]      rs2_q, rs2_d;
    logic                 req_done_q, req_done_d;
    logic                 rsp_done_q, rsp_done_d;
    logic [1:0]           rs_read_q, rs_read_d;
    logic [2:0]           vs_read_q, vs_read_d;
    logic                 rd_clob_q, rd_clob_d;
    logic                 vd_clob_q, vd_clob_d;
    logic                 accept_q, accept_d;
    logic                 err_q, err_d;
    logic                 rej_q, rej_d;
    logic [XLen-1:0]      wb_data_q, wb_data_d;
    vdata_t               vrf_q [NumVregs];
    vdata_t               vrf_d [NumVregs];

    logic                 dreq_v, drsp_r, ereq_v, ersp_r;
    logic                 req_fire, rsp_fire;
    exe_req_t             ereq;
    logic [VIdx-1:0]      vs0_idx, vs1_idx, vd_idx;

    assign vs0_idx = instr_q[15 +: VIdx];
    assign vs1_idx = instr_q[20 +: VIdx];
    assign vd_idx  = instr_q[7 +: VIdx];

    assign mst.dec_req_valid = dreq_v;
    assign mst.dec_rsp_ready = drsp_r;
    assign mst.exe_req_valid = ereq_v;
    assign mst.exe_rsp_ready = ersp_r;
    assign mst.dec_req       = '{id: cur_id_q, instr: instr_q};
    assign mst.exe_req       = ereq;

    assign rej_o    = rej_q;
    assign err_o    = err_q;
    assign wb_valid = (state_q == WB);
    assign wb_rd    = instr_q[11:7];
    assign wb_data  = wb_data_q;

    // Operands not requested by the slave are driven as zero.
    always_comb begin
        ereq            = '0;
        ereq.id         = cur_id_q;
        ereq.instr      = instr_q;
        ereq.rs_data[0] = rs_read_q[0] ? rs1_q : '0;
        ereq.rs_data[1] = rs_read_q[1] ? rs2_q : '0;
        ereq.vs_data[0] = vs_read_q[0] ? vrf_q[vs0_idx] : '0;
        ereq.vs_data[1] = vs_read_q[1] ? vrf_q[vs1_idx] : '0;
        ereq.vs_data[2] = vs_read_q[2] ? vrf_q[vd_idx] : '0;
    end

    always_comb begin
        state_d    = state_q;
        id_cnt_d   = id_cnt_q;
        cur_id_d   = cur_id_q;
        instr_d    = instr_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        req_done_d = req_done_q;
        rsp_done_d = rsp_done_q;
        rs_read_d  = rs_read_q;
        vs_read_d  = vs_read_q;
        rd_clob_d  = rd_clob_q;
        vd_clob_d  = vd_clob_q;
        accept_d   = accept_q;
        err_d      = err_q;
        rej_d      = 1'b0;
        wb_data_d  = wb_data_q;
        vrf_d      = vrf_q;
        in_ready   = 1'b0;
        dreq_v     = 1'b0;
        drsp_r     = 1'b0;
        ereq_v     = 1'b0;
        ersp_r     = 1'b0;
        req_fire   = 1'b0;
        rsp_fire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    instr_d    = in_instr;
                    rs1_d      = in_rs1;
                    rs2_d      = in_rs2;
                    cur_id_d   = id_cnt_q;
                    id_cnt_d   = id_cnt_q + 1'b1;
                    req_done_d = 1'b0;
                    rsp_done_d = 1'b0;
                    state_d    = DEC;
                end
            end
            DEC: begin
                dreq_v   = !req_done_q;
                drsp_r   = !rsp_done_q;
                req_fire = dreq_v && mst.dec_req_ready;
                rsp_fire = drsp_r && mst.dec_rsp_valid;
                if (rsp_fire) begin
                    rs_read_d = mst.dec_rsp.rs_read;
                    vs_read_d = mst.dec_rsp.vs_read;
                    rd_clob_d = mst.dec_rsp.rd_clobber;
                    vd_clob_d = mst.dec_rsp.vd_clobber;
                    accept_d  = mst.dec_rsp.accept;
                    if (mst.dec_rsp.id != cur_id_q) err_d = 1'b1;
                end
                req_done_d = req_done_q | req_fire;
                rsp_done_d = rsp_done_q | rsp_fire;
                if (req_done_d && rsp_done_d) begin
                    req_done_d = 1'b0;
                    rsp_done_d = 1'b0;
                    state_d    = accept_d ? EXE : IDLE;
                    rej_d      = !accept_d;
                end
            end
            EXE: begin
                ereq_v   = !req_done_q;
                ersp_r   = !rsp_done_q;
                req_fire = ereq_v && mst.exe_req_ready;
                rsp_fire = ersp_r && mst.exe_rsp_valid;
                if (rsp_fire) begin
                    wb_data_d = mst.exe_rsp.rd;
                    if (vd_clob_q) vrf_d[vd_idx] = mst.exe_rsp.vd;
                    if (mst.exe_rsp.id != cur_id_q) err_d = 1'b1;
                end
                req_done_d = req_done_q | req_fire;
                rsp_done_d = rsp_done_q | rsp_fire;
                if (req_done_d && rsp_done_d) begin
                    req_done_d = 1'b0;
                    rsp_done_d = 1'b0;
                    state_d    = rd_clob_q ? WB : IDLE;
                end
            end
            WB: begin
                if (wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            id_cnt_q   <= '0;
            cur_id_q   <= '0;
            instr_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            req_done_q <= 1'b0;
            rsp_done_q <= 1'b0;
            rs_read_q  <= '0;
            vs_read_q  <= '0;
            rd_clob_q  <= 1'b0;
            vd_clob_q  <= 1'b0;
            accept_q   <= 1'b0;
            err_q      <= 1'b0;
            rej_q      <= 1'b0;
            wb_data_q  <= '0;
            vrf_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            id_cnt_q   <= id_cnt_d;
            cur_id_q   <= cur_id_d;
            instr_q    <= instr_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            req_done_q <= req_done_d;
            rsp_done_q <= rsp_done_d;
            rs_read_q  <= rs_read_d;
            vs_read_q  <= vs_read_d;
            rd_clob_q  <= rd_clob_d;
            vd_clob_q  <= vd_clob_d;
            accept_q   <= accept_d;
            err_q      <= err_d;
            rej_q      <= rej_d;
            wb_data_q  <= wb_data_d;
            vrf_q      <= vrf_d;
        end
    end
endmodule

// File: tb/tb_xadac_issue.sv
// Bench for xadac_issue: configurable slave, behavioural VRF/id model,
// per-cycle compare process and directed scenarios.
module tb_xadac_issue;
    import xadac_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic        rej_o, err_o, wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    xadac_if x();

    xadac_issue dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .rej_o(rej_o), .err_o(err_o),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .mst(x)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // Slave configuration
    logic        cfg_accept = 1'b1;
    logic [1:0]  cfg_rs_read = 2'b00;
    logic [2:0]  cfg_vs_read = 3'b000;
    logic        cfg_rdc = 1'b0;
    logic        cfg_vdc = 1'b0;
    int          cfg_dec_dly = 0;
    int          cfg_exe_dly = 0;
    id_t         cfg_id_xor = '0;
    logic [31:0] cfg_rd = '0;

    // Slave state
    logic        dec_pend, exe_pend;
    id_t         dec_pid, exe_pid;
    int          dec_cnt, exe_cnt;
    logic [31:0] exe_rs0;
    int          n_dec = 0;
    int          n_exe = 0;
    dec_rsp_t    drsp;
    exe_rsp_t    ersp;
    logic [31:0] src0;

    assign x.dec_req_ready = x.dec_req_valid && (dec_cnt >= cfg_dec_dly);
    assign x.dec_rsp_valid = dec_pend || (x.dec_req_valid && x.dec_req_ready);
    assign x.exe_req_ready = x.exe_req_valid;
    assign x.exe_rsp_valid = exe_pend ? (exe_cnt >= cfg_exe_dly)
                                      : (x.exe_req_valid && cfg_exe_dly == 0);
    assign x.dec_rsp = drsp;
    assign x.exe_rsp = ersp;

    always_comb begin
        drsp            = '0;
        drsp.id         = (dec_pend ? dec_pid : x.dec_req.id) ^ cfg_id_xor;
        drsp.rs_read    = cfg_rs_read;
        drsp.vs_read    = cfg_vs_read;
        drsp.rd_clobber = cfg_rdc;
        drsp.vd_clobber = cfg_vdc;
        drsp.accept     = cfg_accept;
        src0            = exe_pend ? exe_rs0 : x.exe_req.rs_data[0];
        ersp            = '0;
        ersp.id         = (exe_pend ? exe_pid : x.exe_req.id) ^ cfg_id_xor;
        ersp.vd         = {VLanes{src0}};
        ersp.rd         = cfg_rd;
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dec_pend <= 1'b0; dec_pid <= '0; dec_cnt <= 0;
            exe_pend <= 1'b0; exe_pid <= '0; exe_cnt <= 0;
            exe_rs0  <= '0;
        end else begin
            if (x.dec_req_valid && x.dec_req_ready) begin
                dec_cnt <= 0;
                if (!x.dec_rsp_ready) begin
                    dec_pend <= 1'b1;
                    dec_pid  <= x.dec_req.id;
                end
            end else if (x.dec_req_valid) begin
                dec_cnt <= dec_cnt + 1;
            end
            if (dec_pend && x.dec_rsp_ready) dec_pend <= 1'b0;
            if (x.exe_req_valid && x.exe_req_ready) begin
                exe_cnt <= 1;
                if (!(x.exe_rsp_valid && x.exe_rsp_ready)) begin
                    exe_pend <= 1'b1;
                    exe_pid  <= x.exe_req.id;
                    exe_rs0  <= x.exe_req.rs_data[0];
                end
            end else if (exe_pend) begin
                exe_cnt <= exe_cnt + 1;
            end
            if (exe_pend && x.exe_rsp_valid && x.exe_rsp_ready)
                exe_pend <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rstn && x.dec_req_valid && x.dec_req_ready) n_dec <= n_dec + 1;
        if (rstn && x.exe_req_valid && x.exe_req_ready) n_exe <= n_exe + 1;
    end

    // Behavioural model: VRF contents, id sequence, sticky error
    vdata_t      m_vrf [8];
    int          m_id_cnt = 0;
    id_t         m_cur_id = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_rs1 = '0;
    logic [31:0] m_rs2 = '0;
    logic        m_err = 1'b0;
    vdata_t      cap_vs0;
    id_t         last_dec_id;

    function automatic vdata_t m_vs(input int k);
        int f;
        f = (k == 0) ? int'(m_instr[19:15]) :
            (k == 1) ? int'(m_instr[24:20]) : int'(m_instr[11:7]);
        return cfg_vs_read[k] ? m_vrf[f % 8] : '0;
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            chk("err_o", err_o, m_err);
            if (x.dec_req_valid) begin
                chk("dec_req.id", x.dec_req.id, m_cur_id);
                chk("dec_req.instr", x.dec_req.instr, m_instr);
            end
            if (x.dec_req_valid && x.dec_req_ready)
                last_dec_id = x.dec_req.id;
            if (x.dec_rsp_valid && x.dec_rsp_ready && x.dec_rsp.id != m_cur_id)
                m_err = 1'b1;
            if (x.exe_req_valid) begin
                chk("exe_req.id", x.exe_req.id, m_cur_id);
                chk("exe_req.instr", x.exe_req.instr, m_instr);
                chk("rs_data0", x.exe_req.rs_data[0], cfg_rs_read[0] ? m_rs1 : 0);
                chk("rs_data1", x.exe_req.rs_data[1], cfg_rs_read[1] ? m_rs2 : 0);
                chk("vs_data0", x.exe_req.vs_data[0], m_vs(0));
                chk("vs_data1", x.exe_req.vs_data[1], m_vs(1));
                chk("vs_data2", x.exe_req.vs_data[2], m_vs(2));
            end
            if (x.exe_req_valid && x.exe_req_ready)
                cap_vs0 = x.exe_req.vs_data[0];
            if (x.exe_rsp_valid && x.exe_rsp_ready) begin
                if (x.exe_rsp.id != m_cur_id) m_err = 1'b1;
                if (cfg_vdc)
                    m_vrf[m_instr[9:7]] = cfg_rs_read[0] ? {VLanes{m_rs1}} : '0;
            end
            if (wb_valid) begin
                chk("wb_data", wb_data, cfg_rd);
                chk("wb_rd", wb_rd, m_instr[11:7]);
            end
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] rd,
                                       input logic [4:0] r1,
                                       input logic [4:0] r2);
        return {7'h0, r2, r1, 3'd4, rd, 7'h2b};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b);
        int i;
        i = 0;
        @(negedge clk);
        while (!in_ready && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (!in_ready) chk("issue_timeout", 0, 1);
        m_cur_id = id_t'(m_id_cnt);
        m_id_cnt = (m_id_cnt + 1) % 16;
        m_instr  = ins;
        m_rs1    = a;
        m_rs2    = b;
        in_valid = 1'b1;
        in_instr = ins;
        in_rs1   = a;
        in_rs2   = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_vrf[i] = '0;
        m_id_cnt = 0;
        m_err    = 1'b0;
    endtask

    int d0, e0, rej_n;
    logic hit;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dec_req_valid", x.dec_req_valid, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_err", err_o, 0);
        chk("rst_rej", rej_o, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_valids", {x.dec_req_valid, x.dec_rsp_ready,
                           x.exe_req_valid, x.exe_rsp_ready}, 0);

        // Write rs1 replicated into VRF[11 mod 8 = 3]
        cfg_rs_read = 2'b01; cfg_vs_read = 3'b000; cfg_vdc = 1'b1;
        issue(mk(5'd11, 5'd0, 5'd0), 32'h5, 32'h9);
        wait_idle();

        // Read it back through vs1
        cfg_rs_read = 2'b00; cfg_vs_read = 3'b111; cfg_vdc = 1'b0;
        issue(mk(5'd6, 5'd3, 5'd1), 32'h1, 32'h2);
        wait_idle();
        chk("vrf3_readback", cap_vs0, {4{32'h5}});

        // Rejection
        cfg_accept = 1'b0; cfg_vdc = 1'b1; cfg_rs_read = 2'b01;
        e0 = n_exe; rej_n = 0;
        issue(mk(5'd3, 5'd0, 5'd0), 32'h77, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rej_o) begin
                rej_n++;
                chk("rej_in_ready", in_ready, 1);
            end
        end
        chk("rej_pulse_len", rej_n, 1);
        chk("rej_no_exe", n_exe - e0, 0);
        cfg_accept = 1'b1; cfg_vdc = 1'b0;

        // Slow slave; VRF[3] must still hold 5s after the rejection
        cfg_dec_dly = 3; cfg_exe_dly = 5;
        cfg_rs_read = 2'b11; cfg_vs_read = 3'b011;
        d0 = n_dec; e0 = n_exe;
        issue(mk(5'd2, 5'd3, 5'd3), 32'hA5A5_0001, 32'h5A5A_0002);
        wait_idle();
        chk("slow_dec_count", n_dec - d0, 1);
        chk("slow_exe_count", n_exe - e0, 1);
        chk("slow_vs0_after_rej", cap_vs0, {4{32'h5}});
        cfg_dec_dly = 0; cfg_exe_dly = 0;

        // Scalar writeback with a stalled consumer
        cfg_rdc = 1'b1; cfg_rd = 32'hDEAD_BEEF; wb_ready = 1'b0;
        cfg_vs_read = 3'b000;
        issue(mk(5'd17, 5'd0, 5'd0), 32'h1, 32'h1);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            hit = wb_valid;
        end
        chk("wb_seen", hit, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("wb_hold_valid", wb_valid, 1);
            chk("wb_hold_data", wb_data, 32'hDEAD_BEEF);
            chk("wb_hold_rd", wb_rd, 5'd17);
            chk("wb_no_in_ready", in_ready, 0);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("wb_release_ready", in_ready, 1);
        chk("wb_release_valid", wb_valid, 0);
        cfg_rdc = 1'b0;

        // Bad response id sets a sticky error
        cfg_id_xor = 1;
        issue(mk(5'd1, 5'd0, 5'd0), 32'h3, 32'h4);
        wait_idle();
        chk("err_set", err_o, 1);
        cfg_id_xor = 0;
        issue(mk(5'd1, 5'd0, 5'd0), 32'h3, 32'h4);
        wait_idle();
        chk("err_sticky", err_o, 1);

        // Reset while waiting for the execute response
        cfg_exe_dly = 20; cfg_vdc = 1'b1; cfg_rs_read = 2'b01;
        e0 = n_exe;
        issue(mk(5'd3, 5'd0, 5'd0), 32'h7, 32'h0);
        for (int i = 0; i < 20 && n_exe == e0; i++) @(negedge clk);
        @(negedge clk);
        chk("mid_rst_in_exe", x.exe_rsp_ready, 1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valids", {x.dec_req_valid, x.dec_rsp_ready,
                               x.exe_req_valid, x.exe_rsp_ready}, 0);
        chk("mid_rst_err", err_o, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        cfg_exe_dly = 0; cfg_vdc = 1'b0;
        cfg_rs_read = 2'b11; cfg_vs_read = 3'b111;

        // 17 instructions: ids 0..15 then wrap to 0
        for (int i = 0; i < 17; i++) begin
            issue(mk(5'(i), 5'd3, 5'd11), 32'(i * 3), 32'(i + 100));
            wait_idle();
            if (i == 0) begin
                chk("post_rst_id", last_dec_id, 0);
                chk("post_rst_vrf3", cap_vs0, 0);
            end
            if (i == 15) chk("id_15", last_dec_id, 15);
            if (i == 16) chk("id_wrap", last_dec_id, 0);
        end
        chk("final_err_clear", err_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
